// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encoding and the default widths used by the core.
package pipe_ctrl_pkg;

  localparam int PC_WIDTH_DEF      = 32;
  localparam int REG_IDX_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use compare between the EX-stage load destination and
// the decode-stage source registers.
// Ports:
//   rs1_en_i/rs2_en_i, rs1_idx_i/rs2_idx_i : decode source reads
//   rd_en_i, rd_idx_i, is_load_i           : EX-stage destination info
//   hazard_o                               : load-use hazard present
module hazard_detect #(
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     rs1_en_i,
  input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
  input  logic                     rs2_en_i,
  input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
  input  logic                     rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx_i,
  input  logic                     is_load_i,
  output logic                     hazard_o
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load "writing" it never creates a dependency.
  assign rd_live  = is_load_i & rd_en_i & (rd_idx_i != '0);
  assign rs1_hit  = rs1_en_i & (rs1_idx_i == rd_idx_i);
  assign rs2_hit  = rs2_en_i & (rs2_idx_i == rd_idx_i);
  assign hazard_o = rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central stall/flush/redirect controller for the five-stage pipeline.
// Handles load-use bubbles, iterative mul/div occupancy of EX, data-memory
// back-pressure (with a sticky watchdog) and EX redirects. Also keeps a
// saturating count of cycles in which the PC is stalled.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   dec_*                         : decode-stage source reads
//   id_ex_*                       : EX-stage destination / load info
//   ex_mdv_req_i, mdv_done_i      : mul/div request and completion pulse
//   ex_pipe_flush_i/_pc_i         : EX redirect request and target
//   mem_stall_i                   : data memory not ready
//   *_stall_o, *_flush_o          : stage hold / bubble controls
//   redirect_o, redirect_pc_o     : pc_reg redirect
//   mdv_go_o                      : start pulse to the iterative unit
//   mem_timeout_o                 : sticky memory watchdog error
//   stall_cycles_o                : saturating pc-stall cycle count
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow; hazards, redirects and request entry evaluated
// MDV_WAIT | EX held while the iterative mul/div unit works
// MEM_WAIT | whole pipe held while data memory is not ready
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_WIDTH      = PC_WIDTH_DEF,
  parameter int REG_IDX_WIDTH = REG_IDX_WIDTH_DEF,
  parameter int MEM_TIMEOUT   = 255,
  parameter int PERF_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_rs1_en_i,
  input  logic                     dec_rs2_en_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
  input  logic                     id_ex_rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
  input  logic                     id_ex_is_load_i,
  input  logic                     ex_mdv_req_i,
  input  logic                     mdv_done_i,
  input  logic                     ex_pipe_flush_i,
  input  logic [PC_WIDTH-1:0]      ex_pipe_flush_pc_i,
  input  logic                     mem_stall_i,
  output logic                     pc_stall_o,
  output logic                     if_id_stall_o,
  output logic                     id_ex_stall_o,
  output logic                     ex_stall_o,
  output logic                     if_id_flush_o,
  output logic                     id_ex_flush_o,
  output logic                     redirect_o,
  output logic [PC_WIDTH-1:0]      redirect_pc_o,
  output logic                     mdv_go_o,
  output logic                     mem_timeout_o,
  output logic [PERF_WIDTH-1:0]    stall_cycles_o
);

  localparam int WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  timeout_q, timeout_d;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;
  logic                  load_use;
  logic                  mem_hold;

  hazard_detect #(
    .REG_IDX_WIDTH(REG_IDX_WIDTH)
  ) u_hazard_detect (
    .rs1_en_i (dec_rs1_en_i),
    .rs1_idx_i(dec_rs1_idx_i),
    .rs2_en_i (dec_rs2_en_i),
    .rs2_idx_i(dec_rs2_idx_i),
    .rd_en_i  (id_ex_rd_en_i),
    .rd_idx_i (id_ex_rd_idx_i),
    .is_load_i(id_ex_is_load_i),
    .hazard_o (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      perf_q    <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      perf_q    <= perf_d;
    end
  end

  // Outputs are forced quiet while rst is held so a request still asserted
  // across reset cannot leak a stall or a second mdv_go pulse.
  always_comb begin
    state_d       = state_q;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    id_ex_stall_o = 1'b0;
    ex_stall_o    = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    mdv_go_o      = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall_i) begin
            {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_stall_o} = 4'b1111;
            state_d = ST_MEM_WAIT;
          end else if (ex_pipe_flush_i) begin
            redirect_o    = 1'b1;
            redirect_pc_o = ex_pipe_flush_pc_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (ex_mdv_req_i) begin
            mdv_go_o = 1'b1;
            {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_stall_o} = 4'b1111;
            state_d = ST_MDV_WAIT;
          end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
        ST_MDV_WAIT: begin
          if (mdv_done_i) begin
            state_d = ST_RUN;
          end else begin
            {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_stall_o} = 4'b1111;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_stall_i) begin
            {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_stall_o} = 4'b1111;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // The RUN cycle that enters MEM_WAIT is the first stalled cycle, so a
  // MEM_WAIT stall cycle with watchdog value w is consecutive stall w+2.
  assign mem_hold = (state_q == ST_MEM_WAIT) && mem_stall_i;

  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    if (mem_hold) begin
      wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WD_W'(1);
      if ((int'(wdog_q) + 2) >= MEM_TIMEOUT) timeout_d = 1'b1;
    end else if ((state_q == ST_RUN) && mem_stall_i && (MEM_TIMEOUT <= 1)) begin
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    perf_d = perf_q;
    if (pc_stall_o && (perf_q != {PERF_WIDTH{1'b1}})) perf_d = perf_q + PERF_WIDTH'(1);
  end

  assign mem_timeout_o  = timeout_q;
  assign stall_cycles_o = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int PCW  = 32;
  localparam int RIW  = 5;
  localparam int MTO  = 6;
  localparam int PERW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rs1_en, rs2_en;
  logic [RIW-1:0]  rs1_idx, rs2_idx;
  logic            rd_en;
  logic [RIW-1:0]  rd_idx;
  logic            is_load;
  logic            mdv_req, mdv_done;
  logic            flush;
  logic [PCW-1:0]  flush_pc;
  logic            mem_stall;
  logic            pc_stall, if_id_stall, id_ex_stall, ex_stall;
  logic            if_id_flush, id_ex_flush, redirect, mdv_go, mem_timeout;
  logic [PCW-1:0]  redirect_pc;
  logic [PERW-1:0] stall_cycles;
  logic [7:0]      ctl;

  int total = 0;
  int bad   = 0;

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_stall,
                if_id_flush, id_ex_flush, redirect, mdv_go};

  pipe_ctrl #(
    .PC_WIDTH(PCW), .REG_IDX_WIDTH(RIW), .MEM_TIMEOUT(MTO), .PERF_WIDTH(PERW)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_rs1_en_i(rs1_en), .dec_rs2_en_i(rs2_en),
    .dec_rs1_idx_i(rs1_idx), .dec_rs2_idx_i(rs2_idx),
    .id_ex_rd_en_i(rd_en), .id_ex_rd_idx_i(rd_idx), .id_ex_is_load_i(is_load),
    .ex_mdv_req_i(mdv_req), .mdv_done_i(mdv_done),
    .ex_pipe_flush_i(flush), .ex_pipe_flush_pc_i(flush_pc),
    .mem_stall_i(mem_stall),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall),
    .id_ex_stall_o(id_ex_stall), .ex_stall_o(ex_stall),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .mdv_go_o(mdv_go), .mem_timeout_o(mem_timeout),
    .stall_cycles_o(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rs1_en = 0; rs2_en = 0; rs1_idx = 0; rs2_idx = 0;
    rd_en = 0; rd_idx = 0; is_load = 0;
    mdv_req = 0; mdv_done = 0; flush = 0; flush_pc = 0; mem_stall = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'h00); end
    total++;
    if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", redirect_pc, 32'h0); end
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    total++;
    if (stall_cycles !== 4'd0) begin bad++; $display("FAIL reset_perf got=%0d exp=0", stall_cycles); end
    total++;
  endtask

  task automatic test_load_use();
    do_reset();
    is_load = 1; rd_en = 1; rd_idx = 5'd5;
    rs1_en = 1; rs1_idx = 5'd3; rs2_en = 1; rs2_idx = 5'd5;
    #1;
    if (ctl !== 8'b1100_0100) begin bad++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, 8'b1100_0100); end
    total++;
    step();
    is_load = 0; rd_en = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL load_use_bubble got=%b exp=%b", ctl, 8'h00); end
    total++;
    if (stall_cycles !== 4'd1) begin bad++; $display("FAIL load_use_perf got=%0d exp=1", stall_cycles); end
    total++;
  endtask

  task automatic test_x0_and_enables();
    do_reset();
    is_load = 1; rd_en = 1; rd_idx = 5'd0; rs1_en = 1; rs1_idx = 5'd0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL x0_no_stall got=%b exp=%b", ctl, 8'h00); end
    total++;
    rd_idx = 5'd7; rs1_idx = 5'd7; rs2_idx = 5'd7; rs1_en = 0; rs2_en = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL disabled_src got=%b exp=%b", ctl, 8'h00); end
    total++;
    rs1_en = 1;
    #1;
    if (ctl !== 8'b1100_0100) begin bad++; $display("FAIL rs1_match got=%b exp=%b", ctl, 8'b1100_0100); end
    total++;
    rd_en = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL rd_disabled got=%b exp=%b", ctl, 8'h00); end
    total++;
    rd_en = 1; is_load = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL not_load got=%b exp=%b", ctl, 8'h00); end
    total++;
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1; flush_pc = 32'h8000_0040;
    #1;
    if (ctl !== 8'b0000_1110) begin bad++; $display("FAIL flush_ctl got=%b exp=%b", ctl, 8'b0000_1110); end
    total++;
    if (redirect_pc !== 32'h8000_0040) begin bad++; $display("FAIL flush_pc got=%h exp=%h", redirect_pc, 32'h8000_0040); end
    total++;
    // flush beats a simultaneous load-use hazard
    is_load = 1; rd_en = 1; rd_idx = 5'd9; rs1_en = 1; rs1_idx = 5'd9;
    #1;
    if (ctl !== 8'b0000_1110) begin bad++; $display("FAIL flush_vs_load got=%b exp=%b", ctl, 8'b0000_1110); end
    total++;
    step();
    quiet();
    #1;
    if (stall_cycles !== 4'd0) begin bad++; $display("FAIL flush_perf got=%0d exp=0", stall_cycles); end
    total++;
  endtask

  task automatic test_mdv();
    do_reset();
    mdv_req = 1; mdv_done = 1;
    #1;
    if (ctl !== 8'b1111_0001) begin bad++; $display("FAIL mdv_go_ctl got=%b exp=%b", ctl, 8'b1111_0001); end
    total++;
    step();
    mdv_done = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL mdv_wait_%0d got=%b exp=%b", i, ctl, 8'b1111_0000); end
      total++;
      step();
    end
    mdv_done = 1;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL mdv_done_ctl got=%b exp=%b", ctl, 8'h00); end
    total++;
    step();
    quiet();
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL mdv_after got=%b exp=%b", ctl, 8'h00); end
    total++;
    if (stall_cycles !== 4'd11) begin bad++; $display("FAIL mdv_perf got=%0d exp=11", stall_cycles); end
    total++;
  endtask

  task automatic test_mem_timeout();
    do_reset();
    mem_stall = 1;
    for (int i = 0; i < MTO; i++) begin
      #1;
      if (ctl !== 8'b1111_0000 || mem_timeout !== 1'b0) begin
        bad++; $display("FAIL mem_hold_%0d ctl=%b to=%b exp ctl=%b to=0", i, ctl, mem_timeout, 8'b1111_0000);
      end
      total++;
      step();
    end
    if (mem_timeout !== 1'b1) begin bad++; $display("FAIL mem_timeout_set got=%b exp=1", mem_timeout); end
    total++;
    if (stall_cycles !== 4'd6) begin bad++; $display("FAIL mem_perf got=%0d exp=6", stall_cycles); end
    total++;
    mem_stall = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL mem_release got=%b exp=%b", ctl, 8'h00); end
    total++;
    step();
    step();
    if (mem_timeout !== 1'b1) begin bad++; $display("FAIL mem_timeout_sticky got=%b exp=1", mem_timeout); end
    total++;
    do_reset();
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL mem_timeout_clear got=%b exp=0", mem_timeout); end
    total++;
  endtask

  task automatic test_flush_vs_mem();
    do_reset();
    mem_stall = 1; flush = 1; flush_pc = 32'h0000_1234;
    #1;
    if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL fvm_stall got=%b exp=%b", ctl, 8'b1111_0000); end
    total++;
    step();
    mem_stall = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL fvm_release got=%b exp=%b", ctl, 8'h00); end
    total++;
    step();
    if (ctl !== 8'b0000_1110 || redirect_pc !== 32'h0000_1234) begin
      bad++; $display("FAIL fvm_flush ctl=%b pc=%h exp ctl=%b pc=%h", ctl, redirect_pc, 8'b0000_1110, 32'h0000_1234);
    end
    total++;
    step();
    quiet();
  endtask

  task automatic test_reset_mid_mdv();
    do_reset();
    mdv_req = 1;
    step();
    step();
    step();
    if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL rmm_wait got=%b exp=%b", ctl, 8'b1111_0000); end
    total++;
    rst = 1;
    step();
    if (ctl !== 8'h00 || stall_cycles !== 4'd0) begin
      bad++; $display("FAIL rmm_in_reset ctl=%b perf=%0d exp ctl=%b perf=0", ctl, stall_cycles, 8'h00);
    end
    total++;
    mdv_req = 0;
    rst = 0;
    #1;
    if (ctl !== 8'h00) begin bad++; $display("FAIL rmm_after got=%b exp=%b", ctl, 8'h00); end
    total++;
    flush = 1; flush_pc = 32'hCAFE_0000;
    #1;
    if (ctl !== 8'b0000_1110) begin bad++; $display("FAIL rmm_run_state got=%b exp=%b", ctl, 8'b0000_1110); end
    total++;
    step();
    quiet();
  endtask

  task automatic test_perf_saturate();
    do_reset();
    mem_stall = 1;
    for (int i = 0; i < 20; i++) step();
    if (stall_cycles !== 4'd15) begin bad++; $display("FAIL perf_saturate got=%0d exp=15", stall_cycles); end
    total++;
    mem_stall = 0;
    step();
    step();
    if (stall_cycles !== 4'd15) begin bad++; $display("FAIL perf_hold got=%0d exp=15", stall_cycles); end
    total++;
  endtask

  initial begin
    quiet();
    rst = 1;
    test_reset();
    test_load_use();
    test_x0_and_enables();
    test_flush();
    test_mdv();
    test_mem_timeout();
    test_flush_vs_mem();
    test_reset_mid_mdv();
    test_perf_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
